pdu_run_ctrl: RTL
=================

Name: pdu_run_ctrl

Overview:
Debug run-mode controller that sequences CPU execution for the PDU. Debounced button pulses request single-step, N-step or continuous run. The block generates a per-cycle CPU clock enable and halts on any of NBRK programmable PC breakpoints or on a forced halt. It also keeps an executed-cycle counter for the IO bus and panel display.

Parameters:
NBRK, 4, number of breakpoint registers (power of 2, 1..8)
AW, 32, PC and breakpoint address width
SW, 16, step-count width

Ports:
clk  in  1  PDU working clock
rstn  in  1  asynchronous active-low reset
step_p  in  1  one-cycle pulse: start step burst
cont_p  in  1  one-cycle pulse: start continuous run
halt_p  in  1  one-cycle pulse: force stop
step_n  in  SW  instructions per step burst; 0 treated as 1
brk_we  in  1  write breakpoint entry
brk_sel  in  log2(NBRK)  entry index for write
brk_wdata  in  AW  breakpoint address
brk_wen  in  1  enable bit written with the entry
pc  in  AW  current CPU PC
cnt_clr  in  1  clear inst_cnt
cpu_en  out  1  CPU advances at this clk edge
stop  out  1  1 when state is STOP
state  out  2  00 STOP, 01 STEP, 10 RUN
hit  out  1  one-cycle pulse after a breakpoint halt
hit_idx  out  log2(NBRK)  index of last breakpoint hit
inst_cnt  out  32  number of cycles with cpu_en=1

Behaviour:
- Reset is asynchronous and active-low on rstn; every register uses it.
- Values in reset: state=STOP, stop=1, cpu_en=0, hit=0, hit_idx=0, inst_cnt=0, step counter=0, first_r=0.
- Breakpoint addresses and enables reset to 0. A disabled entry never matches.
- If rstn is asserted mid-RUN or mid-STEP, cpu_en drops to 0 immediately, combinationally from the reset state.
- Match: brk_m[i] = en[i] & (brk_addr[i]==pc). any_m = OR of brk_m. Lowest matching index wins for hit_idx.
- first_r is set on entry to STEP or RUN and cleared after the first enabled cycle. It suppresses matching in that first cycle, so run/step can resume from a breakpoint PC.
- stop_now = halt_p | (any_m & ~first_r).
- cpu_en is combinational: (state!=STOP) & ~stop_now. The instruction at a breakpoint PC is therefore NOT executed.
- FSM, registered:
  - STOP: step_p -> STEP, loading the step counter with (step_n==0 ? 1 : step_n). Otherwise cont_p -> RUN. step_p has priority over cont_p when both arrive in one cycle. halt_p in STOP has no effect.
  - STEP: on stop_now -> STOP. Otherwise, when cpu_en=1 the counter decrements; if the counter==1 -> STOP.
  - RUN: on stop_now -> STOP. Otherwise stay.
  - In STEP or RUN, step_p and cont_p are ignored.
- hit: set for exactly one cycle, in the cycle after a transition to STOP caused by a breakpoint match (not by halt_p). hit_idx is registered at the same edge and holds until the next hit.
- When halt_p and a match coincide, the halt still stops the CPU; hit is also asserted, because the match is valid.
- Breakpoint write: the entry updates at the clk edge and takes effect from the next cycle. A write during RUN is allowed.
- inst_cnt: increments by 1 each cycle cpu_en=1 and wraps modulo 2^32. cnt_clr has priority over the increment and loads 0.
- stop = (state==STOP). state is the raw registered FSM value. Encoding 11 is unreachable; if reached, the next state is STOP.

Test Plan:
- Reset, then 1 cycle of step_p with step_n=0 -> cpu_en=1 for exactly 1 cycle, state back to 00, inst_cnt=1.
- step_n=5, step_p, no breakpoints -> cpu_en high for 5 consecutive cycles, inst_cnt=5, stop=1 afterwards.
- Entry 2 = 0x0000_0040 enabled; cont_p; pc increments by 4 per enabled cycle from 0 -> cpu_en falls in the cycle pc==0x40, 16 enabled cycles total, next cycle hit=1 with hit_idx=2. A second cont_p then resumes past 0x40 (first-cycle suppression), with cpu_en=1 at pc==0x40.
- Entries 1 and 3 both = 0x80 enabled; run to 0x80 -> hit_idx=1. Disable entry 1 via brk_we with brk_wen=0 -> the next run to 0x80 gives hit_idx=3.
- step_p and cont_p in the same cycle -> state=01 (STEP). halt_p during RUN -> cpu_en=0 in the same cycle, state=00 next, hit stays 0.
- rstn asserted low mid-RUN with inst_cnt=0x1234 -> cpu_en=0 and inst_cnt=0 without waiting for a clock edge. After release, state=00 and all breakpoint enables=0. cnt_clr with cpu_en=1 -> inst_cnt=0.

Source files
------------

// File: rtl/pdu_run_ctrl.sv
`timescale 1ns/1ps
// Debug run-mode controller: sequences CPU clock enables for single-step, N-step and
// continuous run, halting on programmable PC breakpoints or a forced halt.
module pdu_run_ctrl #(
    parameter int NBRK = 4,
    parameter int AW   = 32,
    parameter int SW   = 16,
    localparam int IW  = (NBRK > 1) ? $clog2(NBRK) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          step_p,
    input  logic          cont_p,
    input  logic          halt_p,
    input  logic [SW-1:0] step_n,
    input  logic          brk_we,
    input  logic [IW-1:0] brk_sel,
    input  logic [AW-1:0] brk_wdata,
    input  logic          brk_wen,
    input  logic [AW-1:0] pc,
    input  logic          cnt_clr,
    output logic          cpu_en,
    output logic          stop,
    output logic [1:0]    state,
    output logic          hit,
    output logic [IW-1:0] hit_idx,
    output logic [31:0]   inst_cnt
);

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_STEP = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    logic [1:0]      state_r;
    logic [1:0]      state_nx;
    logic [AW-1:0]   brk_addr [NBRK];
    logic [NBRK-1:0] brk_en;
    logic [NBRK-1:0] brk_m;
    logic            any_m;
    logic [IW-1:0]   m_idx;
    logic            first_r;
    logic [SW-1:0]   step_cnt;
    logic            stop_now;
    logic            active;
    logic            entering;
    logic            hit_set;

    // Breakpoint table; a write takes effect from the cycle after the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NBRK; i++) begin
                brk_addr[i] <= '0;
            end
            brk_en <= '0;
        end else if (brk_we && (int'(brk_sel) < NBRK)) begin
            brk_addr[brk_sel] <= brk_wdata;
            brk_en[brk_sel]   <= brk_wen;
        end
    end

    always_comb begin
        brk_m = '0;
        for (int i = 0; i < NBRK; i++) begin
            brk_m[i] = brk_en[i] & (brk_addr[i] == pc);
        end
    end

    assign any_m = |brk_m;

    // Scan downward so the lowest matching entry is the one left in m_idx.
    always_comb begin
        m_idx = '0;
        for (int i = NBRK - 1; i >= 0; i--) begin
            if (brk_m[i]) m_idx = IW'(i);
        end
    end

    // step_p/cont_p/halt_p are single-cycle strobes sampled at the clk edge.
    assign stop_now = halt_p | (any_m & ~first_r);
    assign active   = (state_r == ST_STEP) | (state_r == ST_RUN);
    assign entering = (state_r == ST_STOP) & (state_nx != ST_STOP);
    assign hit_set  = active & any_m & ~first_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_STOP;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_STOP: begin
                if (step_p) begin
                    state_nx = ST_STEP;
                end else if (cont_p) begin
                    state_nx = ST_RUN;
                end
            end
            ST_STEP: begin
                if (stop_now) begin
                    state_nx = ST_STOP;
                end else if (step_cnt == SW'(1)) begin
                    state_nx = ST_STOP;
                end
            end
            ST_RUN: begin
                if (stop_now) begin
                    state_nx = ST_STOP;
                end
            end
            default: state_nx = ST_STOP;
        endcase
    end

    // Combinational enable: the instruction sitting at a breakpoint PC is not executed.
    always_comb begin
        cpu_en = (state_r != ST_STOP) & ~stop_now;
        stop   = (state_r == ST_STOP);
        state  = state_r;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_cnt <= '0;
        end else if ((state_r == ST_STOP) && step_p) begin
            step_cnt <= (step_n == '0) ? SW'(1) : step_n;
        end else if ((state_r == ST_STEP) && cpu_en) begin
            step_cnt <= step_cnt - SW'(1);
        end
    end

    // First-cycle suppression lets a run or step leave a breakpoint PC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_r <= 1'b0;
        end else if (entering) begin
            first_r <= 1'b1;
        end else if (cpu_en) begin
            first_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit     <= 1'b0;
            hit_idx <= '0;
        end else begin
            hit <= hit_set;
            if (hit_set) begin
                hit_idx <= m_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_cnt <= '0;
        end else if (cnt_clr) begin
            inst_cnt <= '0;
        end else if (cpu_en) begin
            inst_cnt <= inst_cnt + 32'd1;
        end
    end

endmodule
